coin_change_dispenser: RTL
==========================

// Module: coin_change_dispenser
// PURPOSE
//  Pays change out of the vending datapath. Coin acceptance counts credit in;
//  this block takes an amount owed (in 5c units) and drives the nickel and dime
//  hoppers via four-phase req/ack until it is paid or the hoppers run dry.
//  Sits between the vending control FSM and the two hopper motor drivers.
// PARAMETERS
//  AMT_W           4    width of amount/shortfall, in nickel units (max 15 = 75c)
//  TIMEOUT_CYCLES  255  cycles allowed per handshake phase (used only with ACK_TIMEOUT_EN)
// PORTS
//  clk           in   1      system clock, all state on rising edge
//  reset_n       in   1      asynchronous, active-low reset
//  start         in   1      1-cycle pulse: begin payout of amount
//  amount        in   AMT_W  change owed in 5c units, sampled with start
//  nickel_empty  in   1      nickel hopper empty (level)
//  dime_empty    in   1      dime hopper empty (level)
//  nickel_ack    in   1      nickel hopper ack (four-phase)
//  dime_ack      in   1      dime hopper ack (four-phase)
//  nickel_req    out  1      request one nickel (registered)
//  dime_req      out  1      request one dime (registered)
//  busy          out  1      high from the cycle after start until done
//  done          out  1      1-cycle pulse at end of payout
//  shortfall     out  AMT_W  unpaid remainder, valid from done until next start
//  fault         out  1      handshake timeout, valid with done (0 if macro off)
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; all outputs 0, remaining=0.
//  States: IDLE, SELECT, DREQ, NREQ, RELEASE, DONE.
//  IDLE: start=1 -> latch remaining=amount, clear shortfall/fault, go SELECT.
//    start outside IDLE is ignored. busy=1 in every state except IDLE.
//  SELECT: remaining==0 -> DONE; else remaining>=2 && !dime_empty -> DREQ;
//    else !nickel_empty -> NREQ; else -> DONE (shortfall=remaining).
//    Greedy dime-first. remaining==1 with nickel_empty -> shortfall=1.
//  DREQ/NREQ: matching req held 1 until its ack is sampled 1; that edge: req->0,
//    remaining -= 2 (dime) or 1 (nickel), go RELEASE.
//  RELEASE: wait until the ack of the coin just paid is sampled 0, then SELECT.
//  DONE: done=1 for exactly one cycle, shortfall=remaining, busy->0, go IDLE.
//  Latency: start@T -> SELECT@T+1 -> first req@T+2; amount=0 -> done@T+2.
//  Empty flags are sampled only in SELECT; a change during DREQ/NREQ does not
//    abort the request in progress. Acks outside DREQ/NREQ/RELEASE are ignored;
//    the other hopper's ack is ignored in all states.
//  At most one req is high at any time; reqs never change outside DREQ/NREQ exit.
//  reset_n low mid-handshake: req drops immediately, payout discarded, no done.
//  remaining never underflows (dime requires remaining>=2).
// CONFIGURATION
//  ACK_TIMEOUT_EN defined: a watchdog counter clears on entry to DREQ, NREQ and
//    RELEASE and counts each cycle spent there; reaching TIMEOUT_CYCLES -> req->0,
//    fault=1, go DONE with shortfall=remaining (coin in flight is not credited).
//  ACK_TIMEOUT_EN undefined: no counter; handshakes wait indefinitely; fault tied 0.
// STRUCTURE
//  coin_defs.vh (shared include): state encodings, NICKEL_UNITS=1, DIME_UNITS=2.
//    The vending control FSM uses the same coin constants.
//  Top-level FSM and remaining/shortfall registers in this module.
//  Sub-module hopper_if: one four-phase req/ack unit, instantiated per hopper;
//    ports go, ack -> req, paid, released.
// TESTING
//  1 amount=3, both stocked -> dime handshake then nickel handshake; done, shortfall=0.
//  2 amount=4, dime_empty=1 -> four nickel handshakes, dime_req never 1; shortfall=0.
//  3 amount=3, nickel_empty=1 -> one dime, done, shortfall=1.
//  4 amount=0 -> done at T+2, no req, shortfall=0; start pulsed while busy -> ignored.
//  5 reset_n low during DREQ -> dime_req/busy 0 immediately, no done; restart works.
//  6 (ACK_TIMEOUT_EN, TIMEOUT_CYCLES=8) amount=2, dime_ack stuck 0 -> dime_req drops
//    after 8 cycles in DREQ, done with fault=1, shortfall=2.

Source files
------------

// File: rtl/coin_change_dispenser_pkg.sv
// Shared definitions for the change dispenser: FSM state encodings, coin values
// in nickel units, and the coin-type tag used to remember which hopper is in flight.
package coin_change_dispenser_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SELECT  = 3'd1;
    localparam logic [2:0] ST_DREQ    = 3'd2;
    localparam logic [2:0] ST_NREQ    = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    // Coin values in 5c units; the vending control FSM uses the same constants.
    localparam int NICKEL_UNITS = 1;
    localparam int DIME_UNITS   = 2;

    typedef enum logic {
        COIN_NICKEL = 1'b0,
        COIN_DIME   = 1'b1
    } coin_e;

endpackage

// File: rtl/coin_change_dispenser_hopper_if.sv
// One four-phase req/ack unit for a single coin hopper: raises req on go, drops it
// when the ack is seen (paid) or when aborted; released reports the ack back low.
module coin_change_dispenser_hopper_if (
    input  logic clk,
    input  logic reset_n,
    input  logic go,
    input  logic abort,
    input  logic ack,
    output logic req,
    output logic paid,
    output logic released
);

    assign paid     = req & ack;
    assign released = ~ack;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req <= 1'b0;
        end else if (go) begin
            req <= 1'b1;
        end else if (paid || abort) begin
            req <= 1'b0;
        end
    end

endmodule

// File: rtl/coin_change_dispenser.sv
// Change payout controller: greedy dime-first payout of an owed amount through two
// four-phase hoppers. Optional handshake watchdog enabled by defining ACK_TIMEOUT_EN.
module coin_change_dispenser
    import coin_change_dispenser_pkg::*;
#(
    parameter int AMT_W          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             nickel_empty,
    input  logic             dime_empty,
    input  logic             nickel_ack,
    input  logic             dime_ack,
    output logic             nickel_req,
    output logic             dime_req,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] shortfall,
    output logic             fault
);

    logic [2:0]       state, state_d;
    logic [AMT_W-1:0] remaining;
    coin_e            last_coin;
    logic             dime_ok, dime_go, nickel_go;
    logic             dime_paid, nickel_paid, dime_released, nickel_released;
    logic             coin_released;
    logic             timeout;

    // Dime only when at least two units are owed, so remaining can never underflow.
    assign dime_ok   = (remaining >= AMT_W'(DIME_UNITS)) && !dime_empty;
    assign dime_go   = (state == ST_SELECT) && (remaining != '0) && dime_ok;
    assign nickel_go = (state == ST_SELECT) && (remaining != '0) && !dime_ok && !nickel_empty;

    assign coin_released = (last_coin == COIN_DIME) ? dime_released : nickel_released;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    coin_change_dispenser_hopper_if u_dime_if (
        .clk      (clk),
        .reset_n  (reset_n),
        .go       (dime_go),
        .abort    (timeout),
        .ack      (dime_ack),
        .req      (dime_req),
        .paid     (dime_paid),
        .released (dime_released)
    );

    coin_change_dispenser_hopper_if u_nickel_if (
        .clk      (clk),
        .reset_n  (reset_n),
        .go       (nickel_go),
        .abort    (timeout),
        .ack      (nickel_ack),
        .req      (nickel_req),
        .paid     (nickel_paid),
        .released (nickel_released)
    );

    // NOTE: state_d gets a default before the case so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:    if (start) state_d = ST_SELECT;
            ST_SELECT: begin
                if (dime_go)        state_d = ST_DREQ;
                else if (nickel_go) state_d = ST_NREQ;
                else                state_d = ST_DONE;
            end
            ST_DREQ: begin
                if (dime_paid)      state_d = ST_RELEASE;
                else if (timeout)   state_d = ST_DONE;
            end
            ST_NREQ: begin
                if (nickel_paid)    state_d = ST_RELEASE;
                else if (timeout)   state_d = ST_DONE;
            end
            ST_RELEASE: begin
                if (coin_released)  state_d = ST_SELECT;
                else if (timeout)   state_d = ST_DONE;
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
            shortfall <= '0;
            last_coin <= COIN_NICKEL;
        end else begin
            state <= state_d;
            if (state == ST_IDLE && start) begin
                remaining <= amount;
                shortfall <= '0;
            end
            if (dime_go)   last_coin <= COIN_DIME;
            if (nickel_go) last_coin <= COIN_NICKEL;
            if (state == ST_DREQ && dime_paid)
                remaining <= remaining - AMT_W'(DIME_UNITS);
            if (state == ST_NREQ && nickel_paid)
                remaining <= remaining - AMT_W'(NICKEL_UNITS);
            // A coin still in flight at timeout is not credited.
            if (state_d == ST_DONE && state != ST_DONE)
                shortfall <= remaining;
        end
    end

`ifdef ACK_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            in_wait;
    logic            fault_q;

    assign in_wait = (state == ST_DREQ) || (state == ST_NREQ) || (state == ST_RELEASE);
    assign timeout = in_wait && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign fault   = fault_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt  <= '0;
            fault_q <= 1'b0;
        end else begin
            // Any state change restarts the count, so each wait phase gets a full budget.
            if (state_d != state) wd_cnt <= '0;
            else if (in_wait)     wd_cnt <= wd_cnt + 1'b1;
            if (state == ST_IDLE && start)       fault_q <= 1'b0;
            else if (timeout && state_d == ST_DONE) fault_q <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign fault              = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

endmodule
